// File: rtl/fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader
//
// Drain stage on the read side of a synchronous FIFO. Words are popped
// whenever the FIFO has data and there is room for them. A 2-entry skid buffer
// absorbs the FIFO's one-cycle read latency. The words are then presented as
// fixed-length bursts on a valid/ready stream, with an end-of-burst marker.
// Sustained throughput is one word per clock.
//
// Optional feature: define FIFO_BURST_READER_STATS_EN to add the CNT_W
// parameter and the burst_cnt port. burst_cnt counts completed bursts.
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   asynchronous, active-low reset
//   fifo_empty  in   FIFO empty flag
//   fifo_rd_en  out  FIFO pop request; fifo_dout is valid on the next cycle
//   fifo_dout   in   FIFO read data
//   m_valid     out  stream beat valid
//   m_ready     in   sink ready; a beat transfers on m_valid && m_ready
//   m_data      out  stream data (head of the skid buffer)
//   m_last      out  high on the final beat (BURST_LEN-1) of each burst
//   burst_cnt   out  completed-burst count (FIFO_BURST_READER_STATS_EN only)
// -----------------------------------------------------------------------------
module fifo_burst_reader #(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 16
`ifdef FIFO_BURST_READER_STATS_EN
    ,
    parameter int CNT_W     = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
`ifdef FIFO_BURST_READER_STATS_EN
    ,
    output logic [CNT_W-1:0]  burst_cnt
`endif
);

    localparam int              BEAT_W    = $clog2(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t              state;
    logic [1:0]          occ;          // skid buffer occupancy, 0..2
    logic                inflight_p1;  // a FIFO read issued last cycle lands now
    logic [DATA_W-1:0]   tail_p1;      // second skid entry; the head is m_data
    logic [BEAT_W-1:0]   beat_cnt;
    logic                pop;
    logic [2:0]          fill_nxt;

    assign pop = m_valid && m_ready;

    // Occupancy after this cycle's landing word and pop. A new read is issued
    // only if its word (which lands next cycle) still fits in the two entries.
    assign fill_nxt   = 3'(occ) + 3'(inflight_p1) - 3'(pop);
    assign fifo_rd_en = rst && !fifo_empty && (fill_nxt < 3'd2);

    // ---- stage p1: FIFO read data lands in the skid buffer ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_p1 <= 1'b0;
            occ         <= 2'd0;
            m_valid     <= 1'b0;
            m_data      <= '0;
            tail_p1     <= '0;
        end else begin
            inflight_p1 <= fifo_rd_en;
            occ         <= fill_nxt[1:0];
            m_valid     <= (fill_nxt[1:0] != 2'd0);

            // Head update: it advances on a pop, or it fills when the buffer is empty.
            if (pop) begin
                if (occ == 2'd2)
                    m_data <= tail_p1;
                else if (inflight_p1)
                    m_data <= fifo_dout;
            end else if (occ == 2'd0 && inflight_p1) begin
                m_data <= fifo_dout;
            end

            // A landing word goes to the tail slot when the head stays occupied.
            if (inflight_p1 && ((occ == 2'd1 && !pop) || (occ == 2'd2 && pop)))
                tail_p1 <= fifo_dout;
        end
    end

    // Burst framing. m_last is registered and looks ahead to the next beat index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            m_last    <= 1'b0;
`ifdef FIFO_BURST_READER_STATS_EN
            burst_cnt <= '0;
`endif
        end else if (pop) begin
            if (beat_cnt == LAST_BEAT) begin
                beat_cnt <= '0;
                m_last   <= 1'b0;
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
                m_last   <= ((beat_cnt + 1'b1) == LAST_BEAT);
            end

            case (state)
                IDLE:    state <= ACTIVE;
                ACTIVE:  if (m_last) state <= IDLE;
                default: state <= IDLE;
            endcase

`ifdef FIFO_BURST_READER_STATS_EN
            if (m_last)
                burst_cnt <= burst_cnt + 1'b1;
`endif
        end
    end

endmodule
